// File: rtl/i2c_slave_reg_wr.sv
// i2c_slave_reg_wr: write-only I2C slave that turns received data bytes into
// one-clock register-file write strobes with an auto-incrementing address.
// SCL/SDA are oversampled on clk (clk must be >= 8x the SCL frequency).
// Optional build macro I2C_GLITCH_FILTER_EN adds a 3-sample stability filter
// after the synchronizer (+2 clk on every latency).
module i2c_slave_reg_wr #(
    parameter logic [6:0] DEV_ADDR    = 7'h0A,
    parameter int         NUM_REG     = 30,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       reg_wr_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       busy,
    output logic [3:0] nack_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEV_ADDR,
        S_REG_ADDR,
        S_DATA,
        S_IGNORE
    } state_t;

    localparam logic [8:0] NUM_REG_W = 9'(NUM_REG);

    // Acknowledge sequencing after the 8th bit of a byte
    localparam logic [1:0] ACK_NONE  = 2'd0;
    localparam logic [1:0] ACK_FALL1 = 2'd1;  // waiting for the fall that starts the ACK slot
    localparam logic [1:0] ACK_FALL2 = 2'd2;  // waiting for the fall that ends the 9th clock

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_p0;
    logic                   sda_p0;
    logic                   scl_p1;
    logic                   sda_p1;

    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    state_t                 state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_p1;
    logic                   byte_vld_p1;
    logic [1:0]             ack_step;
    logic                   ack_go;
    logic [7:0]             reg_ptr;

    // Metastability synchronizer; idles high like the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;
    logic       scl_filt;
    logic       sda_filt;

    // Sample history and held line value for the stability filter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_s};
            sda_hist <= {sda_hist[0], sda_s};
            scl_filt <= scl_p0;
            sda_filt <= sda_p0;
        end
    end

    // A line only changes once three consecutive samples agree
    assign scl_p0 = (scl_s == scl_hist[0] && scl_s == scl_hist[1]) ? scl_s : scl_filt;
    assign sda_p0 = (sda_s == sda_hist[0] && sda_s == sda_hist[1]) ? sda_s : sda_filt;
`else
    assign scl_p0 = scl_s;
    assign sda_p0 = sda_s;
`endif

    // Previous-value copies for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_p1 <= 1'b1;
            sda_p1 <= 1'b1;
        end else begin
            scl_p1 <= scl_p0;
            sda_p1 <= sda_p0;
        end
    end

    assign scl_rise  =  scl_p0 & ~scl_p1;
    assign scl_fall  = ~scl_p0 &  scl_p1;
    // SCL must be stable high in both samples, so an SCL edge wins over an SDA edge
    assign start_det = scl_p0 & scl_p1 &  sda_p1 & ~sda_p0;
    assign stop_det  = scl_p0 & scl_p1 & ~sda_p1 &  sda_p0;

    // Protocol FSM: bit capture, byte decisions, ACK drive and write strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            shift_p1    <= '0;
            byte_vld_p1 <= 1'b0;
            ack_step    <= ACK_NONE;
            ack_go      <= 1'b0;
            reg_ptr     <= '0;
            sda_oe      <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            busy        <= 1'b0;
            nack_cnt    <= '0;
        end else begin
            reg_wr_en   <= 1'b0;
            byte_vld_p1 <= 1'b0;

            if (start_det) begin
                state    <= S_DEV_ADDR;
                bit_cnt  <= '0;
                busy     <= 1'b1;
                sda_oe   <= 1'b0;
                ack_step <= ACK_NONE;
                ack_go   <= 1'b0;
            end else if (stop_det) begin
                state    <= S_IDLE;
                bit_cnt  <= '0;
                busy     <= 1'b0;
                sda_oe   <= 1'b0;
                ack_step <= ACK_NONE;
                ack_go   <= 1'b0;
            end else begin
                // Data bits, MSB first; the 9th (ACK) clock is not shifted in
                if (scl_rise && ack_step == ACK_NONE &&
                    (state == S_DEV_ADDR || state == S_REG_ADDR || state == S_DATA)) begin
                    shift_p1 <= {shift_p1[6:0], sda_p0};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_vld_p1 <= 1'b1;
                        ack_step    <= ACK_FALL1;
                    end
                end

                if (scl_fall) begin
                    if (ack_step == ACK_FALL1) begin
                        sda_oe   <= ack_go;
                        ack_step <= ACK_FALL2;
                    end else if (ack_step == ACK_FALL2) begin
                        sda_oe   <= 1'b0;
                        ack_step <= ACK_NONE;
                    end
                end

                if (byte_vld_p1) begin
                    ack_go <= 1'b0;
                    case (state)
                        S_DEV_ADDR: begin
                            if (shift_p1 == {DEV_ADDR, 1'b0}) begin
                                ack_go <= 1'b1;
                                state  <= S_REG_ADDR;
                            end else begin
                                state <= S_IGNORE;
                                if (nack_cnt != 4'hF) nack_cnt <= nack_cnt + 4'd1;
                            end
                        end
                        S_REG_ADDR: begin
                            reg_ptr <= shift_p1;
                            if ({1'b0, shift_p1} < NUM_REG_W) begin
                                ack_go <= 1'b1;
                                state  <= S_DATA;
                            end else begin
                                state <= S_IGNORE;
                                if (nack_cnt != 4'hF) nack_cnt <= nack_cnt + 4'd1;
                            end
                        end
                        S_DATA: begin
                            if ({1'b0, reg_ptr} < NUM_REG_W) begin
                                reg_wr_en <= 1'b1;
                                reg_addr  <= reg_ptr;
                                reg_wdata <= shift_p1;
                                reg_ptr   <= reg_ptr + 8'd1;
                                ack_go    <= 1'b1;
                            end else begin
                                state <= S_IGNORE;
                                if (nack_cnt != 4'hF) nack_cnt <= nack_cnt + 4'd1;
                            end
                        end
                        default: ack_go <= 1'b0;
                    endcase
                end
            end
        end
    end

endmodule
